// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: min:sec game countdown driven by 1 ms ticks, with pause, penalty, defuse and explode.
module countdown_timer_ctrl #(
  parameter int MS_PER_SEC  = 1000,
  parameter int INIT_MIN    = 5,
  parameter int INIT_SEC    = 0,
  parameter int PENALTY_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       penalty,
  input  logic       defused,
  input  logic       uno_ms_timeout,
  output logic       lfsr_rst,
  output logic [6:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic [2:0] state,
  output logic       exploded,
  output logic       is_defused
);
  localparam int MW = MS_PER_SEC > 1 ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MW-1:0] MS_LAST = MW'(MS_PER_SEC - 1);
  typedef enum logic [2:0] {IDLE, RUN, PAUSED, DEFUSED, EXPLODED} st_t;
  st_t st, nxt;
  logic [MW-1:0] ms_cnt, ms_nxt;
  logic sec_ev, zero;
  logic [5:0] dec, sec_sub;
  logic [6:0] min_sub;
  assign state = st;
  // dec never exceeds 59, so a single minute borrow is always enough
  always_comb begin
    sec_ev = uno_ms_timeout && ms_cnt == MS_LAST;
    ms_nxt = uno_ms_timeout ? (sec_ev ? '0 : ms_cnt + 1'b1) : ms_cnt;
    dec = 6'(sec_ev) + (penalty ? 6'(PENALTY_SEC) : 6'd0);
    sec_sub = sec >= dec ? sec - dec : sec + 6'd60 - dec;
    min_sub = sec >= dec ? min : min - 7'd1;
    zero = dec != 6'd0 && min == 7'd0 && sec <= dec;
    nxt = st;
    case (st)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = defused ? DEFUSED : zero ? EXPLODED : pause ? PAUSED : RUN;
      PAUSED:  nxt = defused ? DEFUSED : start ? RUN : PAUSED;
      default: nxt = start ? IDLE : st;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      min <= 7'(INIT_MIN);
      sec <= 6'(INIT_SEC);
      ms_cnt <= '0;
      lfsr_rst <= 1'b0;
      sec_tick <= 1'b0;
      exploded <= 1'b0;
      is_defused <= 1'b0;
    end else begin
      st <= nxt;
      lfsr_rst <= nxt == RUN;
      exploded <= nxt == EXPLODED;
      is_defused <= nxt == DEFUSED;
      sec_tick <= st == RUN && sec_ev && nxt == RUN;
      if (st == RUN && !defused) begin
        ms_cnt <= ms_nxt;
        if (zero) begin
          min <= 7'd0;
          sec <= 6'd0;
        end else if (dec != 6'd0) begin
          min <= min_sub;
          sec <= sec_sub;
        end
      end else if ((st == DEFUSED || st == EXPLODED) && start) begin
        min <= 7'(INIT_MIN);
        sec <= 6'(INIT_SEC);
        ms_cnt <= '0;
      end
    end
  end
endmodule
